// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, default vectors
// and the alignment helper used to qualify redirect targets.
package pc_seq_pkg;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h100;

    typedef enum logic [1:0] {
        S_BOOT   = ST_BOOT,
        S_RUN    = ST_RUN,
        S_HALTED = ST_HALTED
    } seq_state_e;

    // True when addr is a multiple of inc_bytes (inc_bytes is a power of two).
    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned inc_bytes);
        logic [63:0] mask;
        mask = 64'(inc_bytes) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential next-PC adder: pc + INC_BYTES, wrapping modulo 2^XLEN.
module pc_incrementer #(
    parameter int          XLEN      = 64,
    parameter int unsigned INC_BYTES = 4
) (
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_pc_plus_inc
);

    assign o_pc_plus_inc = i_pc + XLEN'(INC_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Front-of-fetch program counter with stall, redirect, trap and halt/resume.
// Misaligned redirect targets are vectored to TRAP_VECTOR with a one-cycle
// misalign_trap pulse. Optional retired-instruction counter: PC_SEQ_INSTRET_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int unsigned     INC_BYTES    = 4
`ifdef PC_SEQ_INSTRET_EN
    ,
    parameter int              CNT_W        = 64
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            fetch_valid,
    output logic            misalign_trap,
    output logic [XLEN-1:0] epc,
    output logic [1:0]      state_o
`ifdef PC_SEQ_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_misalign;
    logic            r_fetch_valid;
    seq_state_e      r_state;

    logic [XLEN-1:0] w_pc_plus_inc;
    logic            w_target_aligned;

    pc_incrementer #(
        .XLEN      (XLEN),
        .INC_BYTES (INC_BYTES)
    ) u_inc (
        .i_pc          (r_pc),
        .o_pc_plus_inc (w_pc_plus_inc)
    );

    assign w_target_aligned = is_aligned(64'(redirect_target), INC_BYTES);

    assign pc            = r_pc;
    assign pc_plus_inc   = w_pc_plus_inc;
    assign fetch_valid   = r_fetch_valid;
    assign misalign_trap = r_misalign;
    assign epc           = r_epc;
    assign state_o       = r_state;

    // Sequencer FSM: BOOT for one cycle, then RUN with the fixed-priority
    // next-PC mux, HALTED freezes the PC until resume or a trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_VECTOR;
            r_epc         <= '0;
            r_misalign    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_state       <= S_BOOT;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_pc          <= RESET_VECTOR;
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (trap_req) begin
                        r_pc  <= TRAP_VECTOR;
                        r_epc <= r_pc;
                    end else if (redirect_valid && !w_target_aligned) begin
                        r_pc       <= TRAP_VECTOR;
                        r_epc      <= redirect_target;
                        r_misalign <= 1'b1;
                    end else if (redirect_valid) begin
                        r_pc <= redirect_target;
                    end else if (halt && !resume) begin
                        // A simultaneous resume cancels the halt; the cycle
                        // then proceeds as an ordinary stall/increment.
                        r_state       <= S_HALTED;
                        r_fetch_valid <= 1'b0;
                    end else if (!stall) begin
                        r_pc <= w_pc_plus_inc;
                    end
                end
                S_HALTED: begin
                    if (trap_req) begin
                        r_pc          <= TRAP_VECTOR;
                        r_epc         <= r_pc;
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end else if (resume) begin
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_pc          <= RESET_VECTOR;
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_INSTRET_EN
    logic [CNT_W-1:0] r_instret;
    assign instret = r_instret;

    // Count every RUN fetch that is neither stalled, trapped nor misaligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (r_state == S_RUN && r_fetch_valid && !stall && !trap_req &&
                     !(redirect_valid && !w_target_aligned)) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural reference model and a
// per-cycle compare process. Define PC_SEQ_INSTRET_EN to cover instret.
module tb_pc_sequencer;

    localparam logic [63:0] TRAPV = 64'h100;
    localparam logic [63:0] RSTV  = 64'h0;
    localparam int          INC   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_valid, trap_req, halt, resume;
    logic [63:0] redirect_target;
    logic [63:0] pc, pc_plus_inc, epc;
    logic        fetch_valid, misalign_trap;
    logic [1:0]  state_o;
`ifdef PC_SEQ_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_pc    = 64'h0;
    logic [63:0] m_epc   = 64'h0;
    logic        m_mis   = 1'b0;
    int          m_state = 0;
    logic [63:0] m_cnt   = 64'h0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .fetch_valid     (fetch_valid),
        .misalign_trap   (misalign_trap),
        .epc             (epc),
        .state_o         (state_o)
`ifdef PC_SEQ_INSTRET_EN
        ,
        .instret         (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural rules, evaluated once per rising edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RSTV; m_epc = 64'h0; m_mis = 1'b0; m_state = 0; m_cnt = 64'h0;
        end else begin
            logic bad;
            bad   = redirect_valid && (redirect_target % INC) != 0;
            m_mis = 1'b0;
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (!stall && !trap_req && !bad) m_cnt = m_cnt + 1;
                if (trap_req)                    begin m_epc = m_pc; m_pc = TRAPV; end
                else if (bad)                    begin m_epc = redirect_target; m_pc = TRAPV; m_mis = 1'b1; end
                else if (redirect_valid)         m_pc = redirect_target;
                else if (halt && !resume)        m_state = 2;
                else if (!stall)                 m_pc = m_pc + INC;
            end else begin
                if (trap_req)    begin m_epc = m_pc; m_pc = TRAPV; m_state = 1; end
                else if (resume) m_state = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("pc",          pc,                   m_pc);
        check("pc_plus_inc", pc_plus_inc,          m_pc + INC);
        check("fetch_valid", 64'(fetch_valid),     64'(m_state == 1));
        check("misalign",    64'(misalign_trap),   64'(m_mis));
        check("epc",         epc,                  m_epc);
        check("state",       64'(state_o),         64'(m_state));
`ifdef PC_SEQ_INSTRET_EN
        check("instret",     instret,              m_cnt);
`endif
    end

    task automatic drive(input logic s, input logic rv, input logic [63:0] rt,
                         input logic tr, input logic h, input logic r);
        @(negedge clk);
        stall = s; redirect_valid = rv; redirect_target = rt;
        trap_req = tr; halt = h; resume = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 64'h0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 0; redirect_valid = 0; redirect_target = 0; trap_req = 0; halt = 0; resume = 0;
        #1 rst = 1'b0;
        #9 rst = 1'b1;
        #1;
        check("L reset pc",    pc, 64'h0);
        check("L reset fv",    64'(fetch_valid), 64'h0);
        check("L reset state", 64'(state_o), 64'h0);
        check("L reset epc",   epc, 64'h0);
        @(posedge clk); #1;
        check("L boot pc", pc, 64'h0);
        check("L boot fv", 64'(fetch_valid), 64'h1);
        idle(); check("L seq4", pc, 64'h4);
        idle(); check("L seq8", pc, 64'h8);
        idle(); check("L seqC", pc, 64'hC);
        // Aligned and misaligned redirects
        drive(0, 1, 64'h100, 0, 0, 0);
        drive(0, 1, 64'h200, 0, 0, 0); check("L redir", pc, 64'h200);
        drive(0, 1, 64'h100, 0, 0, 0);
        drive(0, 1, 64'h202, 0, 0, 0);
        check("L mis pc",  pc, 64'h100);
        check("L mis epc", epc, 64'h202);
        check("L mis pulse", 64'(misalign_trap), 64'h1);
        idle(); check("L mis clear", 64'(misalign_trap), 64'h0);
        idle(); check("L pc108", pc, 64'h108);
        // Stall, then stall with trap
        repeat (3) begin drive(1, 0, 64'h0, 0, 0, 0); check("L stall", pc, 64'h108); end
        idle(); check("L after stall", pc, 64'h10C);
        drive(0, 1, 64'h108, 0, 0, 0);
        drive(1, 0, 64'h0, 1, 0, 0);
        check("L trap pc", pc, 64'h100);
        check("L trap epc", epc, 64'h108);
        // Halt / resume
        drive(0, 1, 64'h110, 0, 0, 0);
        drive(0, 0, 64'h0, 0, 1, 0);
        check("L halt state", 64'(state_o), 64'h2);
        check("L halt fv", 64'(fetch_valid), 64'h0);
        drive(1, 1, 64'h500, 0, 0, 0); check("L halt hold", pc, 64'h110);
        drive(0, 0, 64'h0, 0, 0, 1);
        check("L resume state", 64'(state_o), 64'h1);
        check("L resume pc", pc, 64'h110);
        idle(); check("L pc114", pc, 64'h114);
        drive(0, 0, 64'h0, 0, 1, 1);
        check("L halt+resume", 64'(state_o), 64'h1);
        drive(0, 0, 64'h0, 0, 1, 0);
        drive(0, 0, 64'h0, 1, 0, 0);
        check("L halted trap state", 64'(state_o), 64'h1);
        check("L halted trap pc", pc, 64'h100);
        // Wrap-around
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        check("L wrap inc", pc_plus_inc, 64'h0);
        idle(); check("L wrap pc", pc, 64'h0);
        idle();
        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        check("L async pc",    pc, RSTV);
        check("L async epc",   epc, 64'h0);
        check("L async state", 64'(state_o), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) idle();
        repeat (2) drive(1, 0, 64'h0, 0, 0, 0);
        drive(0, 0, 64'h0, 1, 0, 0);
        check("L run pc",  pc, 64'h100);
        check("L run epc", epc, 64'h28);
`ifdef PC_SEQ_INSTRET_EN
        check("L instret", instret, 64'd10);
`endif
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
